// File: rtl/color_sequencer_if.sv
// Board-side bus of the color sequencer: button/switch/vsync inputs and the
// color-select outputs that feed Top_Display.
interface color_sequencer_if;
  logic       btn_next;
  logic       btn_prev;
  logic       sw_load;
  logic [2:0] sw_color;
  logic       auto_en;
  logic       vsync;
  logic       Black;
  logic       Blue;
  logic       Green;
  logic       Cyan;
  logic       Red;
  logic       Magenta;
  logic       Yellow;
  logic       White;
  logic [2:0] color_idx;
  logic       pending;
  logic       frame_update;

  modport master (
    output btn_next, btn_prev, sw_load, sw_color, auto_en, vsync,
    input  Black, Blue, Green, Cyan, Red, Magenta, Yellow, White,
    input  color_idx, pending, frame_update
  );

  modport slave (
    input  btn_next, btn_prev, sw_load, sw_color, auto_en, vsync,
    output Black, Blue, Green, Cyan, Red, Magenta, Yellow, White,
    output color_idx, pending, frame_update
  );
endinterface

// File: rtl/color_sequencer.sv
// Frame-synchronous color selector: debounced button commands, switch load and
// auto-cycling, all applied only at the start of vertical retrace.
module color_sequencer #(
  parameter int unsigned DEB_CYCLES       = 500000,
  parameter int unsigned FRAMES_PER_COLOR = 60,
  parameter int unsigned VSYNC_ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              reset,
  color_sequencer_if.slave  bus
);

  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int unsigned FC_W  = (FRAMES_PER_COLOR > 1) ? $clog2(FRAMES_PER_COLOR) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FRAMES_PER_COLOR - 1);
  localparam logic             VS_INV   = 1'(VSYNC_ACTIVE_LOW != 0);

  typedef enum logic [0:0] {S_IDLE, S_PEND} state_t;

  // Button bit order: [0] next, [1] prev, [2] load
  logic [2:0]       b_s1, b_s2, deb, deb_d, cmd;
  logic [DEB_W-1:0] deb_cnt [3];
  logic             v_s1, v_s2, v_s3, retrace;
  logic             a_s1, a_s2;

  state_t           state, state_n;
  logic [2:0]       target, target_n;
  logic [2:0]       color_idx, idx_n;
  logic [FC_W-1:0]  fcnt, fcnt_n;
  logic             upd_n;
  logic [2:0]       base, req;
  logic             pending, frame_update;
  logic [7:0]       sel;

  // Synchronizers, debounce counters and command/retrace pulse generation
  always_ff @(posedge clk) begin
    if (!reset) begin
      b_s1    <= '0;
      b_s2    <= '0;
      deb     <= '0;
      deb_d   <= '0;
      cmd     <= '0;
      deb_cnt <= '{default: '0};
      v_s1    <= 1'b0;
      v_s2    <= 1'b0;
      v_s3    <= 1'b0;
      retrace <= 1'b0;
      a_s1    <= 1'b0;
      a_s2    <= 1'b0;
    end else begin
      b_s1    <= {bus.sw_load, bus.btn_prev, bus.btn_next};
      b_s2    <= b_s1;
      deb_d   <= deb;
      cmd     <= deb & ~deb_d;
      v_s1    <= bus.vsync;
      v_s2    <= v_s1;
      v_s3    <= v_s2;
      retrace <= (v_s2 ^ VS_INV) & ~(v_s3 ^ VS_INV);
      a_s1    <= bus.auto_en;
      a_s2    <= a_s1;
      for (int i = 0; i < 3; i++) begin
        if (b_s2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= b_s2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // Request latch / retrace apply / auto-step decision
  always_comb begin
    state_n  = state;
    target_n = target;
    idx_n    = color_idx;
    fcnt_n   = fcnt;
    upd_n    = 1'b0;
    base     = (state == S_PEND) ? target : color_idx;
    req      = base;

    if (cmd[2])      req = bus.sw_color;
    else if (cmd[0]) req = base + 3'd1;
    else if (cmd[1]) req = base - 3'd1;

    if (!a_s2) fcnt_n = '0;

    if (|cmd) begin
      // A command arriving with retrace waits for the following retrace
      target_n = req;
      state_n  = S_PEND;
    end else if (retrace) begin
      if (state == S_PEND) begin
        idx_n   = target;
        upd_n   = 1'b1;
        fcnt_n  = '0;
        state_n = S_IDLE;
      end else if (a_s2) begin
        if (fcnt == FC_LAST) begin
          idx_n  = color_idx + 3'd1;
          upd_n  = 1'b1;
          fcnt_n = '0;
        end else begin
          fcnt_n = fcnt + FC_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      target       <= '0;
      color_idx    <= '0;
      fcnt         <= '0;
      pending      <= 1'b0;
      frame_update <= 1'b0;
      sel          <= 8'h01;
    end else begin
      state        <= state_n;
      target       <= target_n;
      color_idx    <= idx_n;
      fcnt         <= fcnt_n;
      pending      <= (state_n == S_PEND);
      frame_update <= upd_n;
      sel          <= 8'h01 << idx_n;
    end
  end

  assign bus.color_idx    = color_idx;
  assign bus.pending      = pending;
  assign bus.frame_update = frame_update;
  assign bus.Black        = sel[0];
  assign bus.Blue         = sel[1];
  assign bus.Green        = sel[2];
  assign bus.Cyan         = sel[3];
  assign bus.Red          = sel[4];
  assign bus.Magenta      = sel[5];
  assign bus.Yellow       = sel[6];
  assign bus.White        = sel[7];

endmodule

// File: tb/tb_color_sequencer.sv
// Directed bench for color_sequencer with a cycle-level reference model built
// from raw-input histories and the documented latencies.
module tb_color_sequencer;

  localparam int unsigned D  = 4;
  localparam int unsigned F  = 3;
  localparam int unsigned VL = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  color_sequencer_if bus();

  color_sequencer #(
    .DEB_CYCLES(D),
    .FRAMES_PER_COLOR(F),
    .VSYNC_ACTIVE_LOW(VL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int upd_cnt = 0;
  int rise_cnt = 0;
  bit prev_pend = 1'b0;

  // Reference model state: raw-sample histories (bit 0 = sample at this edge)
  logic [15:0] bh [3];
  logic [7:0]  vh;
  logic [2:0]  ah;
  logic [2:0]  mdeb, rise1, rise2;
  int          m_idx, m_tgt, m_fc;
  bit          m_pend, m_upd, m_valid = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  function automatic bit vact(input logic v);
    return (VL != 0) ? !v : v;
  endfunction

  task automatic model_step();
    logic [2:0] raw, cmd;
    bit all_diff, retr, aut;
    int base;
    raw = {bus.sw_load, bus.btn_prev, bus.btn_next};
    if (!reset) begin
      for (int i = 0; i < 3; i++) bh[i] = '0;
      vh = '0; ah = '0; mdeb = '0; rise1 = '0; rise2 = '0;
      m_idx = 0; m_tgt = 0; m_fc = 0; m_pend = 0; m_upd = 0;
      m_valid = 1'b1;
      return;
    end
    vh = {vh[6:0], bus.vsync};
    ah = {ah[1:0], bus.auto_en};
    // A level accepted at edge k is seen as a command two edges later
    cmd = rise2;
    rise2 = rise1;
    rise1 = '0;
    for (int i = 0; i < 3; i++) begin
      bh[i] = {bh[i][14:0], raw[i]};
      all_diff = 1'b1;
      for (int j = 2; j <= int'(D) + 1; j++)
        if (bh[i][j] == mdeb[i]) all_diff = 1'b0;
      if (all_diff) begin
        rise1[i] = ~mdeb[i];
        mdeb[i]  = ~mdeb[i];
      end
    end
    retr = vact(vh[3]) && !vact(vh[4]);
    aut  = ah[2];
    m_upd = 1'b0;
    if (!aut) m_fc = 0;
    if (cmd != 3'b000) begin
      base = m_pend ? m_tgt : m_idx;
      if (cmd[2])      m_tgt = int'(bus.sw_color);
      else if (cmd[0]) m_tgt = (base + 1) % 8;
      else             m_tgt = (base + 7) % 8;
      m_pend = 1'b1;
    end else if (retr && m_pend) begin
      m_idx = m_tgt; m_pend = 1'b0; m_upd = 1'b1; m_fc = 0;
    end else if (retr && aut) begin
      m_fc++;
      if (m_fc == int'(F)) begin
        m_idx = (m_idx + 1) % 8; m_fc = 0; m_upd = 1'b1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("color_idx", int'(bus.color_idx), m_idx);
      chk("pending", int'(bus.pending), int'(m_pend));
      chk("frame_update", int'(bus.frame_update), int'(m_upd));
      chk("onehot", int'({bus.White, bus.Yellow, bus.Magenta, bus.Red,
                          bus.Cyan, bus.Green, bus.Blue, bus.Black}),
          1 << m_idx);
      if (bus.frame_update) upd_cnt++;
      if (bus.pending && !prev_pend) rise_cnt++;
      prev_pend = bus.pending;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: bus.btn_next = v;
      1: bus.btn_prev = v;
      default: bus.sw_load = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    cyc(8);
    set_btn(b, 1'b0);
    cyc(8);
  endtask

  task automatic vpulse();
    bus.vsync = 1'b0;
    cyc(2);
    bus.vsync = 1'b1;
    cyc(6);
  endtask

  function automatic int onehot_now();
    return int'({bus.White, bus.Yellow, bus.Magenta, bus.Red,
                 bus.Cyan, bus.Green, bus.Blue, bus.Black});
  endfunction

  int u0, r0;
  int auto_exp [7] = '{2, 2, 3, 3, 3, 4, 4};
  int reen_exp [3] = '{4, 4, 5};

  initial begin
    bus.btn_next = 1'b0; bus.btn_prev = 1'b0; bus.sw_load = 1'b0;
    bus.sw_color = 3'd0; bus.auto_en = 1'b0; bus.vsync = 1'b1;

    // Reset and idle frames
    cyc(3);
    chk("rst_idx", int'(bus.color_idx), 0);
    chk("rst_black", int'(bus.Black), 1);
    chk("rst_onehot", onehot_now(), 1);
    chk("rst_pending", int'(bus.pending), 0);
    chk("rst_fu", int'(bus.frame_update), 0);
    reset = 1'b1;
    u0 = upd_cnt;
    repeat (4) vpulse();
    chk("idle_idx", int'(bus.color_idx), 0);
    chk("idle_fu_count", upd_cnt - u0, 0);

    // Load 7, then a clean next wraps to 0
    bus.sw_color = 3'd7;
    press(2);
    vpulse();
    chk("load7_idx", int'(bus.color_idx), 7);
    bus.btn_next = 1'b1;
    cyc(7);
    chk("next_pend_early", int'(bus.pending), 0);
    cyc(1);
    chk("next_pend_at8", int'(bus.pending), 1);
    cyc(2);
    bus.btn_next = 1'b0;
    cyc(8);
    u0 = upd_cnt;
    bus.vsync = 1'b0;
    cyc(2);
    bus.vsync = 1'b1;
    cyc(1);
    chk("wrap_idx_before", int'(bus.color_idx), 7);
    cyc(1);
    chk("wrap_idx", int'(bus.color_idx), 0);
    chk("wrap_black", int'(bus.Black), 1);
    chk("wrap_fu", int'(bus.frame_update), 1);
    chk("wrap_pending", int'(bus.pending), 0);
    cyc(1);
    chk("wrap_fu_off", int'(bus.frame_update), 0);
    cyc(4);
    chk("wrap_fu_count", upd_cnt - u0, 1);

    // Bouncy prev from 0
    r0 = rise_cnt;
    for (int i = 0; i < 10; i++) begin
      bus.btn_prev = ~bus.btn_prev;
      cyc(2);
    end
    bus.btn_prev = 1'b1;
    cyc(10);
    bus.btn_prev = 1'b0;
    cyc(8);
    chk("bounce_requests", rise_cnt - r0, 1);
    chk("bounce_pending", int'(bus.pending), 1);
    vpulse();
    chk("bounce_idx", int'(bus.color_idx), 7);
    chk("bounce_white", int'(bus.White), 1);

    // Same-cycle next+load (load wins), then a second next before retrace
    bus.sw_color = 3'd5;
    bus.btn_next = 1'b1;
    bus.sw_load = 1'b1;
    cyc(8);
    bus.btn_next = 1'b0;
    bus.sw_load = 1'b0;
    cyc(8);
    chk("prio_pending", int'(bus.pending), 1);
    chk("prio_idx_held", int'(bus.color_idx), 7);
    press(0);
    vpulse();
    chk("prio_idx", int'(bus.color_idx), 6);
    chk("prio_yellow", int'(bus.Yellow), 1);

    // Auto mode from index 2
    bus.sw_color = 3'd2;
    press(2);
    vpulse();
    chk("auto_start_idx", int'(bus.color_idx), 2);
    bus.auto_en = 1'b1;
    cyc(4);
    for (int i = 0; i < 7; i++) begin
      vpulse();
      chk($sformatf("auto_r%0d", i + 1), int'(bus.color_idx), auto_exp[i]);
    end
    bus.auto_en = 1'b0;
    cyc(4);
    bus.auto_en = 1'b1;
    cyc(4);
    for (int i = 0; i < 3; i++) begin
      vpulse();
      chk($sformatf("reen_r%0d", i + 1), int'(bus.color_idx), reen_exp[i]);
    end
    bus.auto_en = 1'b0;
    cyc(4);

    // Reset while a load of 4 is pending
    bus.sw_color = 3'd4;
    press(2);
    chk("rstpend_pending_before", int'(bus.pending), 1);
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(2);
    u0 = upd_cnt;
    vpulse();
    cyc(2);
    chk("rstpend_idx", int'(bus.color_idx), 0);
    chk("rstpend_pending", int'(bus.pending), 0);
    chk("rstpend_black", int'(bus.Black), 1);
    chk("rstpend_fu_count", upd_cnt - u0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/color_sequencer.md
# color_sequencer

Frame-synchronous controller that selects the active display color for `Top_Display` and drives its eight one-hot color-select inputs (`Black` … `White`). It takes debounced push-button commands, a switch-loaded direct value, and an optional auto-cycle mode. Every change is applied only at the start of vertical retrace, so a frame never shows two colors. It sits between the board I/O and `Top_Display`, and it replaces bench-driven color stepping in system builds.

## Interface
- `DEB_CYCLES`, 500000: consecutive stable cycles needed to accept a button level (10 ms at 50 MHz).
- `FRAMES_PER_COLOR`, 60: retrace events per color step in auto mode. Must be ≥ 1.
- `VSYNC_ACTIVE_LOW`, 1: polarity of `vsync`. With 1, retrace starts on the falling edge.
- `clk`  in  1  system clock; the same clock as `Top_Display`.
- `reset`  in  1  synchronous, active-low reset.
- `btn_next`  in  1  raw, asynchronous push button: advance the color.
- `btn_prev`  in  1  raw, asynchronous push button: step the color back.
- `sw_load`  in  1  raw, asynchronous push button: load `sw_color`.
- `sw_color`  in  3  direct color index (0 Black, 1 Blue, 2 Green, 3 Cyan, 4 Red, 5 Magenta, 6 Yellow, 7 White). Sampled when the `sw_load` edge is accepted.
- `auto_en`  in  1  level input that enables auto-cycling. Passes through a 2-FF synchronizer; no debounce.
- `vsync`  in  1  `vsync` from `Top_Display`.
- `Black`, `Blue`, `Green`, `Cyan`, `Red`, `Magenta`, `Yellow`, `White`  out  1 each  one-hot color selects.
- `color_idx`  out  3  current applied color index.
- `pending`  out  1  a request is latched and waiting for retrace.
- `frame_update`  out  1  one-cycle pulse on the cycle the new color takes effect.

## Operation
- Input conditioning:
  - Each button goes through a 2-FF synchronizer, then a saturating debounce counter of width ⌈log2(DEB_CYCLES+1)⌉.
  - The debounced level flips only after the synchronized input differs from it for `DEB_CYCLES` consecutive cycles. Any bounce clears the counter.
  - A rising edge of the debounced level gives a one-cycle command pulse.
  - `vsync` goes through a 2-FF synchronizer. `retrace` is a one-cycle pulse on the synchronized transition into the active level.
- Request priority within one cycle: load > next > prev. Lower-priority pulses in that cycle are dropped.
- Request target:
  - next: target = idx+1 mod 8, so 7→0.
  - prev: target = idx−1 mod 8, so 0→7.
  - load: target = `sw_color`.
  - next and prev compute from the latched target if one is pending, otherwise from `color_idx`. Two nexts in the same frame therefore advance by 2.
- FSM with 2 states:
  - IDLE: a command pulse latches the target and moves to PEND.
  - PEND: a new command pulse overwrites the target (last wins). On `retrace`, apply the target and return to IDLE.
  - A command and `retrace` in the same cycle: the command is latched and `retrace` is ignored for it. It is applied at the next retrace.
- Auto mode:
  - A frame counter increments on each `retrace` while synchronized `auto_en`=1 and the FSM is in IDLE.
  - When the counter equals `FRAMES_PER_COLOR`−1 at a `retrace`, `color_idx` advances by 1 mod 8 on that retrace and the counter clears.
  - The counter also clears on any manual apply and whenever `auto_en`=0.
  - A manual request pending at a retrace takes precedence over the auto step.
- One-hot outputs are registered decodes of `color_idx`. Exactly one is high at all times.

## Timing
- Reset (`reset`=0 at a `clk` edge):
  - `color_idx`=0, `Black`=1, other colors 0, `pending`=0, `frame_update`=0.
  - FSM in IDLE; frame counter, debounce counters, debounced levels and synchronizers all 0.
- Reset asserted mid-PEND discards the request. Reset has priority over all other events.
- Button latency: raw edge to command pulse is 2 (sync) + `DEB_CYCLES` + 1 cycles. `pending` rises 1 cycle after the command pulse.
- Retrace latency: raw `vsync` edge to `retrace` pulse is 3 cycles.
- On the cycle after the `retrace` pulse, all of the following change together:
  - `color_idx` and the one-hot outputs take the new value;
  - `frame_update`=1 for exactly one cycle;
  - `pending`=0.
- An auto step also produces `frame_update`.
- If the target equals the current index, the apply still occurs and `frame_update` still pulses.

## Test plan
Bench parameters: `DEB_CYCLES`=4, `FRAMES_PER_COLOR`=3, `VSYNC_ACTIVE_LOW`=1.
- Reset, then idle with `vsync` toggling:
  - `color_idx`=0 and `Black`=1 throughout;
  - no `frame_update`.
- Clean `btn_next` press from index 7, then a `vsync` fall:
  - `pending` rises 8 cycles after the press;
  - `color_idx`=0 and `Black`=1 exactly 4 cycles after the `vsync` fall;
  - one `frame_update` pulse.
- Bouncy `btn_prev` (toggled every 2 cycles for 20 cycles, then held high) from index 0:
  - exactly one request;
  - after retrace, `color_idx`=7 and `White`=1.
- `btn_next` and `sw_load` (`sw_color`=5) accepted in the same cycle, then a second `btn_next` before retrace:
  - target goes 5, then 6;
  - after retrace, `color_idx`=6 and `Yellow`=1.
- `auto_en`=1 starting at index 2, 7 retraces:
  - `color_idx` becomes 3 after the 3rd retrace and 4 after the 6th;
  - `auto_en`=0 then clears the counter, so a re-enable takes 3 more retraces to step.
- `reset` pulled low while PEND with target 4, then released, then a retrace:
  - `color_idx` stays 0;
  - `pending`=0;
  - no `frame_update`.
